// File: rtl/bcd_seg_scan_pkg.sv
// Shared constants for the BCD 7-segment scan driver: segment patterns (active-high gfedcba),
// the digit count of the packed BCD word, and the nibble-to-pattern lookup.
package bcd_seg_scan_pkg;

    localparam int unsigned BCD_DIGITS = 5;

    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_E   = 7'h79;
    localparam logic [6:0] SEG_OFF = 7'h00;

    // Non-decimal nibbles render as 'E' so corrupted input is visible on the display.
    function automatic logic [6:0] seg_pattern(input logic [3:0] nibble);
        logic [6:0] pat;
        case (nibble)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_E;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bcd_seg_scan_if.sv
// Data/display bundle between the BCD source and the scan driver.
interface bcd_seg_scan_if #(
    parameter int unsigned NUM_DIGITS = bcd_seg_scan_pkg::BCD_DIGITS
);
    logic [4*NUM_DIGITS-1:0] data_bcd;
    logic                    blank_en;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic [7:0]              seg_out;
    logic [NUM_DIGITS-1:0]   dig_sel;
    logic                    frame_tick;

    modport master (
        output data_bcd, blank_en, dp_mask,
        input  seg_out, dig_sel, frame_tick
    );

    modport slave (
        input  data_bcd, blank_en, dp_mask,
        output seg_out, dig_sel, frame_tick
    );
endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational nibble decoder: 4-bit BCD digit plus blank request to an active-high gfedcba pattern.
module bcd_to_seg7
    import bcd_seg_scan_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        if (!blank) seg = seg_pattern(nibble);
    end

endmodule

// File: rtl/bcd_seg_scan.sv
// Time-multiplexed 7-segment scan driver: per-frame snapshot of a packed BCD word, leading-zero
// blanking, per-slot dead time and registered, polarity-adjusted segment/digit outputs.
module bcd_seg_scan
    import bcd_seg_scan_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned DIGIT_HZ    = 1000,
    parameter int unsigned DEAD_CYC    = 500,
    parameter int unsigned NUM_DIGITS  = BCD_DIGITS,
    parameter bit          SEG_ACT_LOW = 1'b1,
    parameter bit          DIG_ACT_LOW = 1'b1
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    bcd_seg_scan_if.slave bus
);

    localparam int unsigned DIV = CLK_FREQ_HZ / DIGIT_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0]         PRESC_MAX = PW'(DIV - 1);
    localparam logic [PW-1:0]         DEAD_END  = PW'(DEAD_CYC);
    localparam logic [IW-1:0]         IDX_MAX   = IW'(NUM_DIGITS - 1);
    localparam logic [7:0]            SEG_POL   = {8{SEG_ACT_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIG_POL   = {NUM_DIGITS{DIG_ACT_LOW}};

    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   dig_q, dig_d;

    logic                  frame;
    logic [NUM_DIGITS-1:0] lead_zero;
    logic [NUM_DIGITS-1:0] onehot;
    logic [3:0]            cur_nib;
    logic                  cur_blank;
    logic                  cur_dp;
    logic [6:0]            cur_seg;

    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end
    end

    assign frame = (presc_q == '0) && (idx_q == '0);

    // Decode from the value being captured so the first slot of a frame is never stale.
    assign snap_d = frame ? bus.data_bcd : snap_q;
    assign dp_d   = frame ? bus.dp_mask  : dp_q;

    always_comb begin
        logic run;
        run       = 1'b1;
        lead_zero = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            run          = run && (snap_d[4*i +: 4] == 4'd0);
            lead_zero[i] = run;
        end
    end

    always_comb begin
        cur_nib   = '0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        onehot    = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx_q == IW'(i)) begin
                onehot[i] = 1'b1;
                cur_nib   = snap_d[4*i +: 4];
                cur_blank = bus.blank_en && lead_zero[i] && (i != 0);
                cur_dp    = dp_d[i];
            end
        end
    end

    bcd_to_seg7 u_dec (
        .nibble (cur_nib),
        .blank  (cur_blank),
        .seg    (cur_seg)
    );

    always_comb begin
        seg_d = {cur_dp, cur_seg} ^ SEG_POL;
        dig_d = ((presc_q < DEAD_END) ? '0 : onehot) ^ DIG_POL;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            presc_q <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            dp_q    <= '0;
            seg_q   <= SEG_POL;
            dig_q   <= DIG_POL;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            dp_q    <= dp_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
        end
    end

    assign bus.seg_out    = seg_q;
    assign bus.dig_sel    = dig_q;
    assign bus.frame_tick = frame && !sys_rst;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Bench for bcd_seg_scan: directed and random BCD words checked cycle by cycle against a
// frame/slot arithmetic model of the display.
module tb_bcd_seg_scan;

    localparam int unsigned SLOT  = 10;
    localparam int unsigned FRAME = 50;
    localparam int unsigned DEAD  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bcd_seg_scan_if #(.NUM_DIGITS(5)) bus ();

    bcd_seg_scan #(
        .CLK_FREQ_HZ (1000),
        .DIGIT_HZ    (100),
        .DEAD_CYC    (2),
        .NUM_DIGITS  (5),
        .SEG_ACT_LOW (1'b1),
        .DIG_ACT_LOW (1'b1)
    ) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          n = 0;
    logic [19:0] m_snap;
    logic [4:0]  m_dp;
    logic [7:0]  exp_seg;
    logic [4:0]  exp_dig;
    logic [6:0]  seg_tab [0:15];
    logic [4:0]  prev_on;
    int          off_run;
    int          idx, presc, val;
    logic        blank;
    logic [4:0]  act;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, got, exp, n);
        end
    endtask

    // One clock of the display: check this cycle, then predict the next from cycle n's inputs.
    task automatic step();
        @(negedge clk);
        chk("frame_tick", 32'(bus.frame_tick), 32'(n % FRAME == 0));
        chk("seg_out", 32'(bus.seg_out), 32'(exp_seg));
        chk("dig_sel", 32'(bus.dig_sel), 32'(exp_dig));
        act = ~bus.dig_sel;
        chk("one_hot", 32'($countones(act) <= 1), 32'd1);
        if (act != 5'd0) begin
            if (prev_on != 5'd0 && act != prev_on) chk("dead_time", 32'(off_run >= DEAD), 32'd1);
            prev_on = act;
            off_run = 0;
        end else begin
            off_run++;
        end
        if (n % FRAME == 0) begin
            m_snap = bus.data_bcd;
            m_dp   = bus.dp_mask;
        end
        idx   = (n / SLOT) % 5;
        presc = n % SLOT;
        val   = int'((m_snap >> (4 * idx)) & 20'hF);
        blank = bus.blank_en && (idx > 0);
        for (int j = idx; j < 5; j++)
            if (((m_snap >> (4 * j)) & 20'hF) != 20'h0) blank = 1'b0;
        exp_seg = ~{m_dp[idx], blank ? 7'h00 : seg_tab[val]};
        exp_dig = (presc < DEAD) ? 5'h1F : ~(5'b00001 << idx);
        n++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int k);
        repeat (k) step();
    endtask

    task automatic align();
        run((FRAME - (n % FRAME)) % FRAME);
    endtask

    task automatic do_reset(input int k);
        rst = 1'b1;
        #1;
        chk("rst_seg", 32'(bus.seg_out), 32'h0FF);
        chk("rst_dig", 32'(bus.dig_sel), 32'h01F);
        chk("rst_tick", 32'(bus.frame_tick), 32'd0);
        repeat (k) @(posedge clk);
        #1;
        rst     = 1'b0;
        n       = 0;
        exp_seg = 8'hFF;
        exp_dig = 5'h1F;
        prev_on = 5'd0;
        off_run = 0;
    endtask

    function automatic logic [19:0] rnd_bcd();
        logic [19:0] w;
        int          lead;
        w    = '0;
        lead = $urandom_range(0, 5);
        for (int i = 0; i < 5; i++) begin
            if (i < 5 - lead)
                w[4*i +: 4] = ($urandom_range(0, 19) > 17) ? 4'($urandom_range(10, 15))
                                                           : 4'($urandom_range(0, 9));
        end
        return w;
    endfunction

    initial begin
        seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B; seg_tab[3] = 7'h4F;
        seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D; seg_tab[6] = 7'h7D; seg_tab[7] = 7'h07;
        seg_tab[8] = 7'h7F; seg_tab[9] = 7'h6F;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'h79;
        m_snap = '0;
        m_dp   = '0;

        // Scenario 1: plain count-up digits, no blanking.
        bus.data_bcd = 20'h12345;
        bus.blank_en = 1'b0;
        bus.dp_mask  = 5'b00000;
        @(posedge clk);
        #1;
        do_reset(2);
        run(3);
        chk("t1_units_dig", 32'(bus.dig_sel), 32'h1E);
        chk("t1_units_seg", 32'(bus.seg_out), 32'h92);
        run(FRAME - 3);

        // Scenario 2/3: leading-zero blanking, all-zero word with and without blanking.
        bus.data_bcd = 20'h00042;
        bus.blank_en = 1'b1;
        run(FRAME);
        bus.data_bcd = 20'h00000;
        run(FRAME);
        bus.blank_en = 1'b0;
        run(FRAME);

        // Scenario 4: mid-frame change must not tear the current frame.
        bus.data_bcd = 20'h11111;
        align();
        run(25);
        bus.data_bcd = 20'h22222;
        run(10);
        chk("t4_old_dig", 32'(bus.dig_sel), 32'h17);
        chk("t4_old_seg", 32'(bus.seg_out), 32'hF9);
        run(FRAME);
        chk("t4_new_seg", 32'(bus.seg_out), 32'hA4);

        // Scenario 5: invalid nibble shows E, decimal point survives blanking.
        bus.data_bcd = 20'h0000A;
        bus.dp_mask  = 5'b00100;
        bus.blank_en = 1'b1;
        align();
        run(FRAME);
        run(25);
        chk("t5_dp_blank", 32'(bus.seg_out), 32'h7F);
        run(30);
        chk("t5_units_e", 32'(bus.seg_out), 32'h86);

        // Random words, masks and mid-frame changes.
        for (int f = 0; f < 8; f++) begin
            bus.data_bcd = rnd_bcd();
            bus.dp_mask  = 5'($urandom_range(0, 31));
            bus.blank_en = 1'($urandom_range(0, 1));
            run($urandom_range(10, 40));
            bus.data_bcd = rnd_bcd();
            bus.blank_en = 1'($urandom_range(0, 1));
            run($urandom_range(20, 60));
        end

        // Scenario 6: reset in the middle of slot 3.
        bus.data_bcd = 20'h33333;
        bus.dp_mask  = 5'b00000;
        bus.blank_en = 1'b0;
        align();
        run(33);
        chk("t6_pre_dig", 32'(bus.dig_sel), 32'h17);
        bus.data_bcd = 20'h98765;
        do_reset(3);
        run(3);
        chk("t6_restart_dig", 32'(bus.dig_sel), 32'h1E);
        chk("t6_restart_seg", 32'(bus.seg_out), 32'h92);
        run(2 * FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
